// File: rtl/mem_write_checker.sv
// ---------------------------------------------------------------------------
// mem_write_checker
//
// Watches a processor data-memory write port and checks the stores it sees
// against a programmable table of expected (address, data) pairs. The table
// is loaded while idle; a run is then started and ends in a sticky PASS or
// FAIL, with the offending store and table entry captured.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   cfg_we/idx/adr/data   table entry write (IDLE only)
//   n_exp, mode           valid entry count and check mode, latched at start
//                         (mode 0 = terminal, 1 = ordered)
//   start, clear          IDLE->RUN, and PASS/FAIL->IDLE
//   memwrite/dataadr/     monitored store port
//   writedata
//   busy, done, pass,     run status (decoded from the state register)
//   fail
//   fail_code             0 none, 1 mismatch, 2 timeout, 3 bad config
//   fail_idx, fail_adr,   failing entry and captured store
//   fail_data
//   write_count           accepted stores in this run, saturating
//
// Interface semantics: memwrite is a plain strobe with no back-pressure. A
// store is the (dataadr, writedata) pair present on any rising edge where
// memwrite is high; each such edge is exactly one store. cfg_we, start and
// clear are likewise single-edge strobes sampled on the rising edge.
// ---------------------------------------------------------------------------
module mem_write_checker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_adr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [IDX_W:0]    n_exp,
    input  logic              mode,
    input  logic              start,
    input  logic              clear,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [ADDR_W-1:0] fail_adr,
    output logic [DATA_W-1:0] fail_data,
    output logic [CNT_W-1:0]  write_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_MISMATCH = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CODE_BADCFG   = 2'd3;

    // Expected-store table
    logic [ADDR_W-1:0] tbl_adr  [DEPTH];
    logic [DATA_W-1:0] tbl_data [DEPTH];

    // FSM state and run context
    state_t            state, state_nx;
    logic [IDX_W:0]    n_lat, n_lat_nx;
    logic              mode_lat, mode_lat_nx;
    logic [IDX_W-1:0]  ptr, ptr_nx;
    logic [CNT_W-1:0]  cyc_cnt, cyc_cnt_nx;
    logic [CNT_W-1:0]  wr_cnt_nx;
    logic [1:0]        code_nx;
    logic [IDX_W-1:0]  fidx_nx;
    logic [ADDR_W-1:0] fadr_nx;
    logic [DATA_W-1:0] fdata_nx;

    // Decision helpers
    logic [IDX_W-1:0]  last_idx;
    logic              ptr_match;
    logic              last_match;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [CNT_W-1:0]  wr_inc;
    logic              timeout_hit;

    // n_lat is 1..DEPTH whenever RUN is active, so n_lat-1 fits in IDX_W.
    assign last_idx    = IDX_W'(n_lat - 1'b1);
    assign ptr_match   = (dataadr == tbl_adr[ptr]) && (writedata == tbl_data[ptr]);
    assign last_match  = (dataadr == tbl_adr[last_idx]) && (writedata == tbl_data[last_idx]);
    assign wr_inc      = (write_count == '1) ? write_count : write_count + 1'b1;
    assign timeout_hit = (int'(cyc_cnt) + 1) >= TIMEOUT;

    // Terminal mode: lowest entry among 0..n_lat-2 whose address matches.
    // Scanning downward lets the lowest index overwrite any higher hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            if (((i + 1) < int'(n_lat)) && (dataadr == tbl_adr[i])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx    = state;
        n_lat_nx    = n_lat;
        mode_lat_nx = mode_lat;
        ptr_nx      = ptr;
        cyc_cnt_nx  = cyc_cnt;
        wr_cnt_nx   = write_count;
        code_nx     = fail_code;
        fidx_nx     = fail_idx;
        fadr_nx     = fail_adr;
        fdata_nx    = fail_data;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    n_lat_nx    = n_exp;
                    mode_lat_nx = mode;
                    ptr_nx      = '0;
                    wr_cnt_nx   = '0;
                    cyc_cnt_nx  = '0;
                    if ((n_exp == '0) || (n_exp > DEPTH_L)) begin
                        state_nx = S_FAIL;
                        code_nx  = CODE_BADCFG;
                        fidx_nx  = '0;
                        fadr_nx  = '0;
                        fdata_nx = '0;
                    end else begin
                        state_nx = S_RUN;
                    end
                end
            end

            S_RUN: begin
                // A store on the edge takes priority over the timeout check.
                if (memwrite) begin
                    if (mode_lat) begin
                        if (ptr_match) begin
                            wr_cnt_nx = wr_inc;
                            if (ptr == last_idx) begin
                                state_nx = S_PASS;
                            end else begin
                                ptr_nx = ptr + 1'b1;
                            end
                        end else begin
                            state_nx = S_FAIL;
                            code_nx  = CODE_MISMATCH;
                            fidx_nx  = ptr;
                            fadr_nx  = dataadr;
                            fdata_nx = writedata;
                        end
                    end else begin
                        if (last_match) begin
                            wr_cnt_nx = wr_inc;
                            state_nx  = S_PASS;
                        end else if (hit) begin
                            wr_cnt_nx = wr_inc;
                            ptr_nx    = hit_idx;
                        end else begin
                            state_nx = S_FAIL;
                            code_nx  = CODE_MISMATCH;
                            fidx_nx  = last_idx;
                            fadr_nx  = dataadr;
                            fdata_nx = writedata;
                        end
                    end
                end else begin
                    cyc_cnt_nx = cyc_cnt + 1'b1;
                    if (timeout_hit) begin
                        state_nx = S_FAIL;
                        code_nx  = CODE_TIMEOUT;
                        fidx_nx  = ptr;
                        fadr_nx  = '0;
                        fdata_nx = '0;
                    end
                end
            end

            S_PASS, S_FAIL: begin
                if (clear) begin
                    state_nx   = S_IDLE;
                    ptr_nx     = '0;
                    cyc_cnt_nx = '0;
                    wr_cnt_nx  = '0;
                    code_nx    = CODE_NONE;
                    fidx_nx    = '0;
                    fadr_nx    = '0;
                    fdata_nx   = '0;
                end
            end

            default: state_nx = S_IDLE;
        endcase
    end

    // State and run-context registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            n_lat       <= '0;
            mode_lat    <= 1'b0;
            ptr         <= '0;
            cyc_cnt     <= '0;
            write_count <= '0;
            fail_code   <= '0;
            fail_idx    <= '0;
            fail_adr    <= '0;
            fail_data   <= '0;
        end else begin
            state       <= state_nx;
            n_lat       <= n_lat_nx;
            mode_lat    <= mode_lat_nx;
            ptr         <= ptr_nx;
            cyc_cnt     <= cyc_cnt_nx;
            write_count <= wr_cnt_nx;
            fail_code   <= code_nx;
            fail_idx    <= fidx_nx;
            fail_adr    <= fadr_nx;
            fail_data   <= fdata_nx;
        end
    end

    // Table storage: writable only while idle, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_adr[i]  <= '0;
                tbl_data[i] <= '0;
            end
        end else if ((state == S_IDLE) && cfg_we) begin
            tbl_adr[cfg_idx]  <= cfg_adr;
            tbl_data[cfg_idx] <= cfg_data;
        end
    end

    assign busy = (state == S_RUN);
    assign pass = (state == S_PASS);
    assign fail = (state == S_FAIL);
    assign done = pass || fail;

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 8;
    localparam int IDX_W   = 3;
    localparam int TIMEOUT = 20;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic              is_pass;
        logic              is_fail;
        logic [1:0]        code;
        logic [IDX_W-1:0]  idx;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  cnt;
        logic [15:0]       lat;
    } res_t;
    localparam int RES_W = $bits(res_t);

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [ADDR_W-1:0] cfg_adr;
    logic [DATA_W-1:0] cfg_data;
    logic [IDX_W:0]    n_exp;
    logic              mode, start, clear, memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;
    logic              busy, done, pass, fail;
    logic [1:0]        fail_code;
    logic [IDX_W-1:0]  fail_idx;
    logic [ADDR_W-1:0] fail_adr;
    logic [DATA_W-1:0] fail_data;
    logic [CNT_W-1:0]  write_count;

    always #5 clk = ~clk;

    mem_write_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr), .cfg_data(cfg_data),
        .n_exp(n_exp), .mode(mode), .start(start), .clear(clear),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .fail_code(fail_code), .fail_idx(fail_idx), .fail_adr(fail_adr),
        .fail_data(fail_data), .write_count(write_count)
    );

    int edge_cnt   = 0;
    int start_edge = 0;
    always @(posedge clk) edge_cnt++;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [RES_W-1:0] exp_q[$];
    res_t cur_exp;

    // Reference table and store schedule
    logic [ADDR_W-1:0] m_adr  [DEPTH];
    logic [DATA_W-1:0] m_data [DEPTH];
    bit                s_we   [$];
    logic [ADDR_W-1:0] s_adr  [$];
    logic [DATA_W-1:0] s_data [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Walks the schedule one edge at a time applying the checking rules;
    // once the schedule is used up the port is idle until timeout.
    function automatic res_t model(input int n, input bit ord);
        res_t r;
        int   ptr  = 0;
        int   idle = 0;
        int   cnt  = 0;
        r = '0;
        if (n == 0 || n > DEPTH) begin
            r.is_fail = 1'b1; r.code = 2'd3; r.lat = 16'd0;
            return r;
        end
        for (int e = 1; e <= s_we.size() + TIMEOUT + 1; e++) begin
            bit                we;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            int                hit;
            we = (e - 1 < s_we.size()) ? s_we[e-1] : 1'b0;
            a  = (e - 1 < s_we.size()) ? s_adr[e-1] : '0;
            d  = (e - 1 < s_we.size()) ? s_data[e-1] : '0;
            r.lat = 16'(e);
            if (we) begin
                if (ord) begin
                    if (a == m_adr[ptr] && d == m_data[ptr]) begin
                        cnt = (cnt < CNT_MAX) ? cnt + 1 : cnt;
                        if (ptr == n - 1) begin
                            r.is_pass = 1'b1; r.cnt = CNT_W'(cnt);
                            return r;
                        end
                        ptr++;
                    end else begin
                        r.is_fail = 1'b1; r.code = 2'd1; r.idx = IDX_W'(ptr);
                        r.adr = a; r.data = d; r.cnt = CNT_W'(cnt);
                        return r;
                    end
                end else begin
                    if (a == m_adr[n-1] && d == m_data[n-1]) begin
                        cnt = (cnt < CNT_MAX) ? cnt + 1 : cnt;
                        r.is_pass = 1'b1; r.cnt = CNT_W'(cnt);
                        return r;
                    end
                    hit = -1;
                    for (int i = 0; i < n - 1; i++)
                        if (hit < 0 && a == m_adr[i]) hit = i;
                    if (hit >= 0) begin
                        ptr = hit;
                        cnt = (cnt < CNT_MAX) ? cnt + 1 : cnt;
                    end else begin
                        r.is_fail = 1'b1; r.code = 2'd1; r.idx = IDX_W'(n - 1);
                        r.adr = a; r.data = d; r.cnt = CNT_W'(cnt);
                        return r;
                    end
                end
            end else begin
                idle++;
                if (idle == TIMEOUT) begin
                    r.is_fail = 1'b1; r.code = 2'd2; r.idx = IDX_W'(ptr);
                    r.cnt = CNT_W'(cnt);
                    return r;
                end
            end
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_sched();
        s_we.delete(); s_adr.delete(); s_data.delete();
    endtask

    task automatic add_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        s_we.push_back(1'b1); s_adr.push_back(a); s_data.push_back(d);
    endtask

    task automatic add_idle(input int k);
        for (int i = 0; i < k; i++) begin
            s_we.push_back(1'b0); s_adr.push_back($urandom); s_data.push_back($urandom);
        end
    endtask

    task automatic cfg_write(input int idx, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_adr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_adr[idx] = a; m_data[idx] = d;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_status"}, {busy, done, pass, fail, fail_code, fail_idx, write_count}, '0);
        check({tag, "_capture"}, {fail_adr, fail_data}, '0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check_zero("clear");
    endtask

    // Start a run with the current schedule, let it finish, check the sticky
    // outputs, then clear back to IDLE.
    task automatic do_run(input int n, input bit ord, input bit poke);
        res_t r;
        int   k;
        r = model(n, ord);
        exp_q.push_back(r);
        cur_exp = r;
        n_exp = (IDX_W+1)'(n); mode = ord; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cfg_we = 1'b0; start_edge = edge_cnt;
        if (r.lat != 0) check("busy_after_start", busy, 1);
        for (int i = 0; i < s_we.size(); i++) begin
            memwrite = s_we[i]; dataadr = s_adr[i]; writedata = s_data[i];
            if (poke) begin
                cfg_we = 1'($urandom_range(0, 1)); cfg_idx = IDX_W'($urandom);
                cfg_adr = $urandom; cfg_data = $urandom;
                n_exp = (IDX_W+1)'($urandom); mode = 1'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        memwrite = 1'b0; cfg_we = 1'b0; start = 1'b0;
        k = 0;
        while (!done && k < TIMEOUT + 5) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_within_budget", done, 1);
        if (!done) exp_q.delete();
        @(negedge clk); #1;
        check("sticky_pass", pass, cur_exp.is_pass);
        check("sticky_fail", fail, cur_exp.is_fail);
        check("sticky_code", fail_code, cur_exp.code);
        check("sticky_idx", fail_idx, cur_exp.idx);
        check("sticky_adr", fail_adr, cur_exp.adr);
        check("sticky_data", fail_data, cur_exp.data);
        check("sticky_count", write_count, cur_exp.cnt);
        @(posedge clk); #1;
        do_clear();
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        bit   prev_done;
        res_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_done = 1'b0;
            end else begin
                if (done && !prev_done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", done, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pass", pass, e.is_pass);
                        check("fail", fail, e.is_fail);
                        check("fail_code", fail_code, e.code);
                        check("fail_idx", fail_idx, e.idx);
                        check("fail_adr", fail_adr, e.adr);
                        check("fail_data", fail_data, e.data);
                        check("write_count", write_count, e.cnt);
                        check("done_latency", edge_cnt - start_edge, e.lat);
                        check("busy_at_done", busy, 0);
                    end
                end
                prev_done = done;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int n, len, c, pos, idx, lim;
        bit ord;
        reset = 1'b1;
        cfg_we = 0; cfg_idx = '0; cfg_adr = '0; cfg_data = '0;
        n_exp = '0; mode = 0; start = 0; clear = 0;
        memwrite = 0; dataadr = '0; writedata = '0;
        for (int i = 0; i < DEPTH; i++) begin m_adr[i] = '0; m_data[i] = '0; end
        #3;
        check_zero("reset");
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Terminal mode, two entries, ends in pass
        cfg_write(0, 32'd80, 32'h1234);
        cfg_write(1, 32'd84, 32'hFFFF7F02);
        clear_sched(); add_store(32'd80, 32'd7); add_store(32'd84, 32'hFFFF7F02);
        do_run(2, 1'b0, 1'b0);

        // Same table, unknown address then a late store to 84
        clear_sched(); add_store(32'd88, 32'd5); add_store(32'd84, 32'hFFFF7F02);
        do_run(2, 1'b0, 1'b0);

        // Ordered mode, skipped entry
        cfg_write(0, 32'd0, 32'd1); cfg_write(1, 32'd4, 32'd2); cfg_write(2, 32'd8, 32'd3);
        clear_sched(); add_store(32'd0, 32'd1); add_store(32'd8, 32'd3);
        do_run(3, 1'b1, 1'b0);

        // Ordered mode, stalls after two entries -> timeout at ptr 2
        clear_sched(); add_store(32'd0, 32'd1); add_idle(3); add_store(32'd4, 32'd2);
        do_run(3, 1'b1, 1'b0);

        // Pure timeout
        clear_sched();
        do_run(2, 1'b0, 1'b0);

        // Bad configuration, then a one-entry pass
        clear_sched(); add_store(32'd16, 32'hA5);
        do_run(0, 1'b0, 1'b0);
        do_run(9, 1'b1, 1'b0);
        cfg_write(0, 32'd16, 32'hA5);
        do_run(1, 1'b0, 1'b0);

        // Table write in the same cycle as start
        cfg_we = 1'b1; cfg_idx = '0; cfg_adr = 32'd200; cfg_data = 32'd9;
        m_adr[0] = 32'd200; m_data[0] = 32'd9;
        clear_sched(); add_store(32'd200, 32'd9);
        do_run(1, 1'b1, 1'b0);

        // write_count saturation
        cfg_write(0, 32'd100, 32'd1); cfg_write(1, 32'd104, 32'd2);
        clear_sched();
        for (int i = 0; i < 40; i++) add_store(32'd100, $urandom);
        add_store(32'd104, 32'd2);
        do_run(2, 1'b0, 1'b0);

        // Reset in the middle of a run
        cfg_write(0, 32'd40, 32'd4); cfg_write(1, 32'd44, 32'd5);
        n_exp = 4'd2; mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; memwrite = 1'b1; dataadr = 32'd40; writedata = 32'd4;
        @(posedge clk); #1;
        memwrite = 1'b0;
        check("pre_reset_count", write_count, 1);
        check("pre_reset_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check_zero("async_reset");
        for (int i = 0; i < DEPTH; i++) begin m_adr[i] = '0; m_data[i] = '0; end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        clear_sched();
        do_run(0, 1'b0, 1'b0);
        clear_sched(); add_store(32'd0, 32'd0);
        do_run(2, 1'b0, 1'b0);

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            for (int j = 0; j < 3; j++)
                cfg_write($urandom_range(0, DEPTH - 1), 4 * $urandom_range(0, 7), $urandom_range(0, 3));
            n   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, DEPTH);
            ord = 1'($urandom_range(0, 1));
            lim = (n >= 1 && n <= DEPTH) ? n : DEPTH;
            clear_sched();
            pos = 0;
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                c = $urandom_range(0, 9);
                if (c < 2) begin
                    add_idle($urandom_range(1, 3));
                end else if (c == 2) begin
                    add_store(4 * $urandom_range(0, 7), $urandom_range(0, 3));
                end else if (ord) begin
                    add_store(m_adr[pos % lim], m_data[pos % lim]);
                    pos++;
                end else begin
                    idx = $urandom_range(0, lim - 1);
                    add_store(m_adr[idx], (c < 7) ? m_data[idx] : 32'($urandom_range(0, 3)));
                end
            end
            do_run(n, ord, 1'($urandom_range(0, 1)));
        end

        @(negedge clk); #1;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
